// File: rtl/step_ctrl_frontend.sv
// Board-input front end for the 4-bit step counter: synchronise, debounce, mode cycling,
// load strobe capture and a prescaled count-enable tick.
module step_ctrl_frontend #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TICK_DIV        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_load,
  input  logic       sw_run,
  input  logic [3:0] sw_data,
  output logic       load,
  output logic       count_en,
  output logic [1:0] c,
  output logic [3:0] data_in
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PreW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);

  // Encoding doubles as the c output value.
  typedef enum logic [1:0] {
    StPlus3 = 2'b00,
    StPlus1 = 2'b01,
    StHold  = 2'b11
  } mode_e;

  // Bit layout: [0] mode, [1] load, [2] run, [6:3] data.
  logic [6:0]      sync1_q, sync2_q;
  logic [2:0]      stable_q;
  logic [CntW-1:0] db_cnt_q [3];
  logic [1:0]      stable_dly_q, event_q;
  logic [PreW-1:0] presc_q;
  logic            load_q, count_en_q;
  logic [3:0]      data_q;
  mode_e           state_q, state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {sw_data, sw_run, btn_load, btn_mode};
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == CntLast) begin
          stable_q[i] <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  // Registered rising-edge events for the two push-buttons.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_dly_q <= '0;
      event_q      <= '0;
    end else begin
      stable_dly_q <= stable_q[1:0];
      event_q      <= stable_q[1:0] & ~stable_dly_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_q     <= 1'b0;
      data_q     <= '0;
      presc_q    <= '0;
      count_en_q <= 1'b0;
    end else begin
      load_q <= event_q[1];
      if (event_q[1]) data_q <= sync2_q[6:3];
      // A load pulse suppresses the tick and restarts the prescaler phase.
      if (!stable_q[2] || event_q[1]) begin
        presc_q    <= '0;
        count_en_q <= 1'b0;
      end else begin
        count_en_q <= (presc_q == PreLast);
        presc_q    <= (presc_q == PreLast) ? '0 : presc_q + PreW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StPlus3;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (event_q[0]) begin
      unique case (state_q)
        StPlus3: state_d = StPlus1;
        StPlus1: state_d = StHold;
        default: state_d = StPlus3;
      endcase
    end
    c = state_q;
  end

  assign load     = load_q;
  assign count_en = count_en_q;
  assign data_in  = data_q;

endmodule

// File: tb/tb_step_ctrl_frontend.sv
// Randomised bench for step_ctrl_frontend: cycle-by-cycle behavioural model plus directed
// literal checks of latency, mode cycling, tick period, collision and reset behaviour.
module tb_step_ctrl_frontend;

  localparam int DB = 4;
  localparam int TD = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_mode = 1'b0, btn_load = 1'b0, sw_run = 1'b0;
  logic [3:0] sw_data = 4'd0;
  logic       load, count_en;
  logic [1:0] c;
  logic [3:0] data_in;

  int total = 0;
  int passed = 0;

  step_ctrl_frontend #(
    .DEBOUNCE_CYCLES(DB),
    .TICK_DIV       (TD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_mode(btn_mode),
    .btn_load(btn_load),
    .sw_run  (sw_run),
    .sw_data (sw_data),
    .load    (load),
    .count_en(count_en),
    .c       (c),
    .data_in (data_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: sync = raw delayed two edges; a debounced level flips once the last
  // DB synchronised samples all disagree with it; effects land two edges after the flip.
  logic [6:0]    rh0, rh1, s;
  logic [DB-1:0] win [3];
  logic [3:0]    sh [3];
  logic          nxt;
  int            mode_m = 0;
  logic [3:0]    data_m = 4'd0;
  logic          load_m = 1'b0, ce_m = 1'b0;
  int            t = 0, r = 0;

  function automatic int c_of(input int m);
    return (m == 0) ? 0 : (m == 1) ? 1 : 3;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      rh0 = '0; rh1 = '0;
      for (int i = 0; i < 3; i++) begin
        win[i] = '0;
        sh[i]  = '0;
      end
      mode_m = 0; data_m = '0; load_m = 1'b0; ce_m = 1'b0; r = t;
    end else begin
      s   = rh1;
      rh1 = rh0;
      rh0 = {sw_data, sw_run, btn_load, btn_mode};
      for (int i = 0; i < 3; i++) begin
        win[i] = {win[i][DB-2:0], s[i]};
        nxt = sh[i][0];
        if (win[i] == {DB{~sh[i][0]}}) nxt = ~sh[i][0];
        sh[i] = {sh[i][2:0], nxt};
      end
      load_m = sh[1][2] & ~sh[1][3];
      if (load_m) data_m = s[6:3];
      if (sh[0][2] & ~sh[0][3]) mode_m = (mode_m + 1) % 3;
      t++;
      if (!sh[2][1] || load_m) begin
        r = t;
        ce_m = 1'b0;
      end else begin
        ce_m = ((t - r) % TD) == 0;
      end
    end
    #1;
    check("model_load", int'(load), int'(load_m));
    check("model_count_en", int'(count_en), int'(ce_m));
    check("model_c", int'(c), c_of(mode_m));
    check("model_data_in", int'(data_in), int'(data_m));
  end

  task automatic watch(input int n, output int loads, output int ces, output int first_load,
                       output int first_ce, output int last_ce);
    loads = 0; ces = 0; first_load = -1; first_ce = -1; last_ce = -1;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (load) begin
        loads++;
        if (first_load < 0) first_load = k;
      end
      if (count_en) begin
        ces++;
        if (first_ce < 0) first_ce = k;
        last_ce = k;
      end
    end
  endtask

  task automatic press_mode(input int hold);
    @(negedge clk);
    btn_mode = 1'b1;
    repeat (hold) @(negedge clk);
    btn_mode = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int l1, l2, l3, e1, e2, fl, fl2, fc, lc;
    int exp_c [4] = '{1, 3, 0, 1};
    bit found;

    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_load", int'(load), 0);
    check("idle_count_en", int'(count_en), 0);
    check("idle_c", int'(c), 0);
    check("idle_data_in", int'(data_in), 0);

    // Short glitch on load button
    @(negedge clk);
    btn_load = 1'b1;
    repeat (3) @(negedge clk);
    btn_load = 1'b0;
    watch(15, l1, e1, fl, fc, lc);
    check("glitch_no_load", l1, 0);

    // Clean load press
    @(negedge clk);
    sw_data  = 4'b1011;
    btn_load = 1'b1;
    watch(10, l1, e1, fl, fc, lc);
    check("load_latency", fl - 1, 7);
    watch(10, l2, e1, fl2, fc, lc);
    @(negedge clk);
    btn_load = 1'b0;
    watch(15, l3, e1, fl2, fc, lc);
    check("load_once", l1 + l2 + l3, 1);
    check("load_data", int'(data_in), 11);

    // Mode cycling with bounces between presses
    for (int p = 0; p < 4; p++) begin
      if (p > 0) begin
        press_mode(2);
        check("bounce_no_step", int'(c), exp_c[p-1]);
      end
      press_mode(10);
      check("mode_step", int'(c), exp_c[p]);
    end

    // Run ticks
    @(negedge clk);
    sw_run = 1'b1;
    watch(60, l1, e1, fl, fc, lc);
    check("tick_count", e1, 6);
    check("tick_first", fc - 1, 13);
    check("tick_span", lc - fc, 40);
    @(negedge clk);
    sw_run = 1'b0;
    watch(10, l1, e1, fl, fc, lc);
    watch(20, l1, e2, fl, fc, lc);
    check("tick_stopped", e2, 0);

    // Load pulse landing on a tick
    @(negedge clk);
    sw_run = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(posedge clk);
      #1;
      if (count_en) found = 1'b1;
    end
    check("collision_tick_seen", int'(found), 1);
    if (found) begin
      btn_load = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check("collision_load", int'(load), 1);
      check("collision_no_tick", int'(count_en), 0);
      btn_load = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("collision_next_tick", int'(count_en), 1);
    end

    // Reset in the middle of a mode debounce while running
    @(negedge clk);
    btn_mode = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_load", int'(load), 0);
    check("rst_count_en", int'(count_en), 0);
    check("rst_c", int'(c), 0);
    check("rst_data_in", int'(data_in), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      check("rst_refill_c", int'(c), (k == 8) ? 1 : 0);
    end
    @(negedge clk);
    btn_mode = 1'b0;
    sw_run   = 1'b0;
    repeat (15) @(negedge clk);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(0, 7) == 0) btn_load = ~btn_load;
      if ($urandom_range(0, 15) == 0) sw_run = ~sw_run;
      if ($urandom_range(0, 9) == 0) sw_data = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
